// File: rtl/d8m_sensor_emulator.sv
// Synthetic raw-sensor source: emits FVAL/LVAL-framed 12-bit pixels with
// programmable geometry and deterministic test patterns on the pixel clock.
module d8m_sensor_emulator #(
  parameter int H_ACTIVE  = 640,
  parameter int H_BLANK   = 160,
  parameter int V_ACTIVE  = 480,
  parameter int V_BLANK   = 2000,
  parameter int FV_LV_GAP = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic [11:0] D,
  output logic        FVAL,
  output logic        LVAL,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FV_LEAD,
    S_LINE,
    S_HBLANK,
    S_FV_TRAIL,
    S_VBLANK
  } state_t;

  localparam logic [15:0] GAP_LAST = 16'(FV_LV_GAP - 1);
  localparam logic [15:0] HB_LAST  = 16'(H_BLANK - 1);
  localparam logic [15:0] VB_LAST  = 16'(V_BLANK - 1);
  localparam logic [15:0] Y_LAST   = 16'(V_ACTIVE - 1);
  localparam logic [11:0] X_LAST   = 12'(H_ACTIVE - 1);
  localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [11:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [2:0]  bar_q, bar_d;
  logic [11:0] bar_cnt_q, bar_cnt_d;
  logic [1:0]  sel_q, sel_d;
  logic [11:0] fill_q, fill_d;
  logic [15:0] fcnt_q, fcnt_d;

  logic [11:0] pix;
  logic [11:0] d_q, d_d;
  logic        fval_q, fval_d;
  logic        lval_q, lval_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_count_q, frame_count_d;

  // Frame sequencer: cnt_q times the gap/blank phases, x/y walk the active area
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    bar_d     = bar_q;
    bar_cnt_d = bar_cnt_q;
    sel_d     = sel_q;
    fill_d    = fill_q;
    fcnt_d    = fcnt_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_FV_LEAD;
          cnt_d   = '0;
          sel_d   = pattern_sel;
          fill_d  = fcnt_q[11:0];
        end
      end
      S_FV_LEAD: begin
        if (cnt_q == GAP_LAST) begin
          state_d   = S_LINE;
          cnt_d     = '0;
          x_d       = '0;
          y_d       = '0;
          bar_d     = '0;
          bar_cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_LINE: begin
        // Bar index advances every H_ACTIVE/8 pixels without a divider
        if (bar_cnt_q == BAR_LAST) begin
          bar_cnt_d = '0;
          bar_d     = bar_q + 3'd1;
        end else begin
          bar_cnt_d = bar_cnt_q + 12'd1;
        end
        if (x_q == X_LAST) begin
          cnt_d   = '0;
          state_d = (y_q == Y_LAST) ? S_FV_TRAIL : S_HBLANK;
        end else begin
          x_d = x_q + 12'd1;
        end
      end
      S_HBLANK: begin
        if (cnt_q == HB_LAST) begin
          state_d   = S_LINE;
          cnt_d     = '0;
          x_d       = '0;
          y_d       = y_q + 16'd1;
          bar_d     = '0;
          bar_cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_FV_TRAIL: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_VBLANK;
          cnt_d   = '0;
          fcnt_d  = fcnt_q + 16'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_VBLANK: begin
        if (cnt_q == VB_LAST) begin
          cnt_d = '0;
          if (enable) begin
            state_d = S_FV_LEAD;
            sel_d   = pattern_sel;
            fill_d  = fcnt_q[11:0];
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output stage: every port is a flop decoded from the sequencer state
  always_comb begin
    case (sel_q)
      2'd0:    pix = x_q;
      2'd1:    pix = {bar_q, 9'h000};
      2'd2:    pix = (x_q[3] ^ y_q[3]) ? 12'hFFF : 12'h000;
      default: pix = fill_q;
    endcase
    lval_d        = (state_q == S_LINE);
    d_d           = lval_d ? pix : 12'h000;
    fval_d        = (state_q == S_FV_LEAD) || (state_q == S_LINE) ||
                    (state_q == S_HBLANK)  || (state_q == S_FV_TRAIL);
    frame_start_d = (state_q == S_FV_LEAD) && (cnt_q == 16'd0);
    frame_count_d = fcnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      bar_q         <= '0;
      bar_cnt_q     <= '0;
      sel_q         <= '0;
      fill_q        <= '0;
      fcnt_q        <= '0;
      d_q           <= '0;
      fval_q        <= 1'b0;
      lval_q        <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      bar_q         <= bar_d;
      bar_cnt_q     <= bar_cnt_d;
      sel_q         <= sel_d;
      fill_q        <= fill_d;
      fcnt_q        <= fcnt_d;
      d_q           <= d_d;
      fval_q        <= fval_d;
      lval_q        <= lval_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign D           = d_q;
  assign FVAL        = fval_q;
  assign LVAL        = lval_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_d8m_sensor_emulator.sv
// Scoreboard bench for d8m_sensor_emulator: stimulus queues expected pixels per
// frame, a negedge monitor pops/compares them and checks frame/line geometry.
module tb_d8m_sensor_emulator;
  localparam int HA  = 16;
  localparam int HB  = 2;
  localparam int VA  = 16;
  localparam int VB  = 3;
  localparam int GAP = 1;
  localparam int FV_HIGH = 2 * GAP + VA * HA + (VA - 1) * HB;  // 288

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [11:0] D;
  logic        FVAL, LVAL, frame_start;
  logic [15:0] frame_count;

  int          nvec = 0;
  int          nfail = 0;
  logic [11:0] exp_q[$];
  logic [15:0] exp_fc = 16'd0;
  int          rise_idx = 0;

  logic [11:0] bars_tbl [16] = '{12'h000, 12'h000, 12'h200, 12'h200,
                                 12'h400, 12'h400, 12'h600, 12'h600,
                                 12'h800, 12'h800, 12'hA00, 12'hA00,
                                 12'hC00, 12'hC00, 12'hE00, 12'hE00};
  logic [1:0]  pats [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  always #5 clk = ~clk;

  d8m_sensor_emulator #(
    .H_ACTIVE (HA),
    .H_BLANK  (HB),
    .V_ACTIVE (VA),
    .V_BLANK  (VB),
    .FV_LV_GAP(GAP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .pattern_sel(pattern_sel),
    .D          (D),
    .FVAL       (FVAL),
    .LVAL       (LVAL),
    .frame_start(frame_start),
    .frame_count(frame_count)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [1:0] p, input logic [11:0] fill);
    logic [11:0] v;
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < HA; x++) begin
        case (p)
          2'd0:    v = 12'(x);
          2'd1:    v = bars_tbl[x];
          2'd2:    v = ((x >= 8) != (y >= 8)) ? 12'hFFF : 12'h000;
          default: v = fill;
        endcase
        exp_q.push_back(v);
      end
    end
  endtask

  task automatic wait_frame_start();
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < 1000);
    if (!frame_start) begin
      nvec++; nfail++;
      $display("FAIL timeout_frame_start: no pulse after %0d cycles", n);
    end
  endtask

  task automatic wait_lval();
    int n = 0;
    do begin @(negedge clk); n++; end while (!LVAL && n < 1000);
    if (!LVAL) begin
      nvec++; nfail++;
      $display("FAIL timeout_lval: LVAL still 0 after %0d cycles", n);
    end
  endtask

  task automatic wait_fval_low();
    int n = 0;
    do begin @(negedge clk); n++; end while (FVAL && n < 1000);
    if (FVAL) begin
      nvec++; nfail++;
      $display("FAIL timeout_fval_low: FVAL still 1 after %0d cycles", n);
    end
  endtask

  // Monitor: pixel scoreboard plus line/frame geometry tracking
  initial begin
    int   fhi, flo, lhi, llo;
    logic fval_p, lval_p, first_line;
    fhi = 0; flo = 0; lhi = 0; llo = 0;
    fval_p = 1'b0; lval_p = 1'b0; first_line = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        fhi = 0; flo = 0; lhi = 0; llo = 0;
        fval_p = 1'b0; lval_p = 1'b0; first_line = 1'b0;
        rise_idx = 0;
        exp_fc = 16'd0;
      end else begin
        if (frame_start || (FVAL && !fval_p))
          chk("frame_start_at_fval_rise", 16'(frame_start), 16'(FVAL && !fval_p));
        if (LVAL) begin
          chk("lval_within_fval", 16'(FVAL), 16'd1);
          if (exp_q.size() == 0) begin
            nvec++; nfail++;
            $display("FAIL pixel_underflow: got D=0x%h, expected no pixel", D);
          end else begin
            chk("pixel", 16'(D), 16'(exp_q.pop_front()));
          end
        end else begin
          chk("d_zero_blank", 16'(D), 16'd0);
        end
        if (FVAL && !fval_p) begin
          if (rise_idx >= 1 && rise_idx <= 5) chk("vblank_len", 16'(flo), 16'(VB));
          rise_idx++;
          first_line = 1'b1;
        end
        if (!FVAL && fval_p) begin
          chk("fval_high_len", 16'(fhi), 16'(FV_HIGH));
          chk("trail_gap", 16'(llo), 16'(GAP));
          exp_fc++;
          chk("frame_count_at_fall", frame_count, exp_fc);
        end
        if (LVAL && !lval_p) begin
          if (first_line) chk("lead_gap", 16'(llo), 16'(GAP));
          else            chk("hblank_len", 16'(llo), 16'(HB));
          first_line = 1'b0;
        end
        if (!LVAL && lval_p) chk("line_len", 16'(lhi), 16'(HA));
        if (FVAL) fhi = fval_p ? fhi + 1 : 1; else fhi = 0;
        if (!FVAL) flo = fval_p ? 1 : flo + 1; else flo = 0;
        if (LVAL) lhi = lval_p ? lhi + 1 : 1;
        if (FVAL && !LVAL) llo = (lval_p || !fval_p) ? 1 : llo + 1;
        fval_p = FVAL;
        lval_p = LVAL;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; pattern_sel = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_D", 16'(D), 16'd0);
    chk("rst_FVAL", 16'(FVAL), 16'd0);
    chk("rst_LVAL", 16'(LVAL), 16'd0);
    chk("rst_frame_start", 16'(frame_start), 16'd0);
    chk("rst_frame_count", frame_count, 16'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_FVAL", 16'(FVAL), 16'd0);
    chk("idle_frame_start", 16'(frame_start), 16'd0);

    // Continuous run: ramp, bars, checker, then three frame-fill frames
    pattern_sel = pats[0];
    push_frame(pats[0], 12'h000);
    enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_frame_start();
      if (k < 5) begin
        pattern_sel = pats[k+1];
        push_frame(pats[k+1], 12'(k + 1));
      end else begin
        wait_lval();
        enable = 1'b0;
      end
    end
    wait_fval_low();
    repeat (VB + 20) @(negedge clk);
    chk("drop_frames_started", 16'(rise_idx), 16'd6);
    chk("drop_idle_FVAL", 16'(FVAL), 16'd0);
    chk("drop_frame_count", frame_count, 16'd6);
    chk("queue_drained", 16'(exp_q.size()), 16'd0);

    // Reset in the middle of a line
    pattern_sel = 2'd0;
    push_frame(2'd0, 12'h000);
    enable = 1'b1;
    wait_lval();
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    enable = 1'b0;
    #1;
    chk("midline_rst_D", 16'(D), 16'd0);
    chk("midline_rst_FVAL", 16'(FVAL), 16'd0);
    chk("midline_rst_LVAL", 16'(LVAL), 16'd0);
    chk("midline_rst_frame_count", frame_count, 16'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_FVAL", 16'(FVAL), 16'd0);
    chk("post_rst_frame_count", frame_count, 16'd0);

    // Wrap: counter preset to 16'hFFFF, one pattern-3 frame
    pattern_sel = 2'd3;
    push_frame(2'd3, 12'hFFF);
    exp_fc = 16'hFFFF;
    force dut.fcnt_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.fcnt_q;
    @(negedge clk);
    enable = 1'b1;
    wait_frame_start();
    enable = 1'b0;
    wait_fval_low();
    chk("wrap_frame_count", frame_count, 16'h0000);
    repeat (VB + 5) @(negedge clk);
    chk("wrap_queue_drained", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/d8m_sensor_emulator.md
# d8m_sensor_emulator

Synthetic raw-sensor source that drives the same parallel pixel interface the camera capture path consumes: 12-bit pixel data `D` qualified by frame-valid `FVAL` and line-valid `LVAL`. It replaces the D8M module on the bench and in lab bring-up. It emits frames of programmable geometry filled with deterministic test patterns, so the capture, VIP and CVO pipeline can be checked against known pixels without a sensor attached. It runs on the pixel clock domain: `D`, `FVAL` and `LVAL` change only on rising `clk`.

## Interface

Parameters:
- `H_ACTIVE`, default 640: pixels per line. Must be a multiple of 8 and ≤ 4095.
- `H_BLANK`, default 160: LVAL-low cycles between lines. Must be ≥ 1.
- `V_ACTIVE`, default 480: lines per frame. Must be ≥ 1.
- `V_BLANK`, default 2000: FVAL-low cycles between frames. Must be ≥ 1.
- `FV_LV_GAP`, default 4: FVAL-high, LVAL-low cycles before the first line and after the last line. Must be ≥ 1.

Ports (clock and reset first):
- `clk` in 1: pixel clock. Single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run request. Sampled only when a frame may start.
- `pattern_sel` in 2: pattern mode. Latched at each frame start.
- `D` out 12: pixel data. 0 whenever `LVAL`=0.
- `FVAL` out 1: frame valid.
- `LVAL` out 1: line valid. High only while `FVAL`=1.
- `frame_start` out 1: one-cycle pulse coincident with the `FVAL` rising edge.
- `frame_count` out 16: completed-frame counter.

## Operation

- All outputs are registered.
- Reset values: `D`=0, `FVAL`=0, `LVAL`=0, `frame_start`=0, `frame_count`=0. After reset the FSM is in IDLE and all internal counters are 0.
- FSM states and transitions:
  - IDLE: outputs low. If `enable`=1, go to FV_LEAD, latch `pattern_sel`, and pulse `frame_start`.
  - FV_LEAD: `FVAL`=1, `LVAL`=0 for `FV_LV_GAP` cycles, then go to LINE.
  - LINE: `LVAL`=1 for `H_ACTIVE` cycles, with the column counter x = 0..H_ACTIVE-1.
    - If more lines remain, go to HBLANK.
    - After line `V_ACTIVE`-1, go to FV_TRAIL.
  - HBLANK: `LVAL`=0 for `H_BLANK` cycles, increment the line counter y, then go to LINE.
  - FV_TRAIL: `FVAL`=1, `LVAL`=0 for `FV_LV_GAP` cycles, then go to VBLANK and increment `frame_count` (mod 2^16) as `FVAL` falls.
  - VBLANK: `FVAL`=0 for `V_BLANK` cycles.
    - At the end, if `enable`=1, go to FV_LEAD with a new `frame_start`; otherwise go to IDLE.
- Patterns (`sel` latched; x and y are the current column and line):
  - 0, horizontal ramp: `D` = x zero-extended to 12 bits.
  - 1, colour bars: `D` = {bar[2:0], 9'h000}. `bar` increments every `H_ACTIVE`/8 pixels and resets to 0 at each line start. Use a counter, not a divider.
  - 2, checkerboard: `D` = (x[3]^y[3]) ? 12'hFFF : 12'h000.
  - 3, frame fill: `D` = `frame_count[11:0]` as sampled at frame start.
- Boundary conditions:
  - Deasserting `enable` mid-frame has no effect; the frame always completes, including VBLANK.
  - `pattern_sel` changes mid-frame are ignored until the next frame start.
  - Asynchronous reset at any point forces the reset values immediately. Partial lines and frames are abandoned and `frame_count` returns to 0.
  - `frame_count` wraps from 16'hFFFF to 0.

## Timing

- From IDLE with `enable`=1 sampled at edge N: `FVAL`=1 and `frame_start`=1 after edge N+1.
- First `LVAL`=1 occurs `FV_LV_GAP` cycles after `FVAL` rises.
- `D` is valid in the same cycle as `LVAL`. The first pixel (x=0) coincides with the `LVAL` rising edge.
- Line period = `H_ACTIVE` + `H_BLANK` cycles.
- `FVAL` high time = 2·`FV_LV_GAP` + `V_ACTIVE`·`H_ACTIVE` + (`V_ACTIVE`-1)·`H_BLANK` cycles.
- Frame period in continuous run = `FVAL` high time + `V_BLANK`.
- `frame_count` updates in the same cycle that `FVAL` goes low.
- `frame_start` never occurs while `FVAL`=1.

## Test plan

- **Reset:** assert `reset_n`=0 mid-LINE → next sample shows `D`=0, `FVAL`=0, `LVAL`=0, `frame_count`=0; after release with `enable`=0, outputs stay low.
- **Geometry:** params H_ACTIVE=8, H_BLANK=2, V_ACTIVE=2, V_BLANK=3, FV_LV_GAP=1, `enable`=1 → `FVAL` high 20 cycles, `LVAL` pulses 8/2/8, `FVAL` low 3 cycles, then `frame_start` again.
- **Ramp:** pattern 0, H_ACTIVE=8 → each line `D`=0,1,...,7, with `D`=0 in blanking.
- **Bars and checker:**
  - Pattern 1, H_ACTIVE=16 → `D` pairs 0x000,0x000,0x200,0x200,...,0xE00,0xE00.
  - Pattern 2, H_ACTIVE=32, V_ACTIVE=16 → line 0 shows `D`=0x000 for x=0..7 and 0xFFF for x=8..15; line 8 is inverted.
- **Enable and pattern changes:**
  - Drop `enable` during line 0 → frame completes, `frame_count` increments to 1, FSM goes to IDLE after VBLANK.
  - Change `pattern_sel` mid-frame → current frame unchanged; the next frame uses the new mode.
- **Frame fill and wrap:** pattern 3 over 3 frames → `D` equals 0, 1, 2 per frame; force `frame_count`=16'hFFFF → next `FVAL` fall gives 0.
